// File: rtl/muladd_pkg.sv
// Shared types and the shift-and-clamp helper for the multiply-accumulate engine.
package muladd_pkg;

    typedef enum logic [1:0] {
        MULADD_ADD,
        MULADD_SUB,
        MULADD_LOAD,
        MULADD_CLEAR
    } muladd_op_t;

    // Working width of sat_shift; callers sign-extend into it and truncate the result.
    localparam int unsigned SAT_CALC_W = 64;

    function automatic logic signed [SAT_CALC_W-1:0] sat_shift(
        input logic signed [SAT_CALC_W-1:0] v,
        input int unsigned                  shift,
        input int unsigned                  sat_w
    );
        logic signed [SAT_CALC_W-1:0] sh;
        logic signed [SAT_CALC_W-1:0] hi;
        logic signed [SAT_CALC_W-1:0] lo;
        logic signed [SAT_CALC_W-1:0] r;
        sh = v >>> shift;
        hi = (64'sd1 <<< (sat_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (sat_w - 1));
        if (sh > hi) begin
            r = hi;
        end else if (sh < lo) begin
            r = lo;
        end else begin
            r = sh;
        end
        return r;
    endfunction

endpackage

// File: rtl/muladd_mult.sv
// Registered signed multiplier forming the stage-1 product; the register loads only when ce_i is high.
module muladd_mult #(
    parameter int unsigned A_W = 16,
    parameter int unsigned B_W = 16
) (
    input  logic                     clk_i,
    input  logic                     ce_i,
    input  logic signed [A_W-1:0]    a_i,
    input  logic signed [B_W-1:0]    b_i,
    output logic signed [A_W+B_W-1:0] p_o
);

    localparam int unsigned PW = A_W + B_W;

`ifdef MULADD_ICE40
    logic [15:0] a16;
    logic [15:0] b16;
    logic [31:0] o32;

    assign a16 = 16'(a_i);
    assign b16 = 16'(b_i);

    SB_MAC16 #(
        .A_SIGNED                 (1'b1),
        .B_SIGNED                 (1'b1),
        .PIPELINE_16x16_MULT_REG2 (1'b1),
        .TOPOUTPUT_SELECT         (2'b11),
        .BOTOUTPUT_SELECT         (2'b11)
    ) u_mac (
        .CLK        (clk_i),
        .CE         (ce_i),
        .C          (16'h0000),
        .A          (a16),
        .B          (b16),
        .D          (16'h0000),
        .AHOLD      (1'b0),
        .BHOLD      (1'b0),
        .CHOLD      (1'b0),
        .DHOLD      (1'b0),
        .IRSTTOP    (1'b0),
        .IRSTBOT    (1'b0),
        .ORSTTOP    (1'b0),
        .ORSTBOT    (1'b0),
        .OLOADTOP   (1'b0),
        .OLOADBOT   (1'b0),
        .ADDSUBTOP  (1'b0),
        .ADDSUBBOT  (1'b0),
        .OHOLDTOP   (1'b0),
        .OHOLDBOT   (1'b0),
        .CI         (1'b0),
        .ACCUMCI    (1'b0),
        .SIGNEXTIN  (1'b0),
        .O          (o32),
        .CO         (),
        .ACCUMCO    (),
        .SIGNEXTOUT ()
    );

    assign p_o = o32[PW-1:0];
`else
    always_ff @(posedge clk_i) begin
        if (ce_i) begin
            p_o <= PW'(a_i) * PW'(b_i);
        end
    end
`endif

endmodule

// File: rtl/muladd_acc.sv
// Multi-channel signed multiply-accumulate: stage 1 registers the op and product,
// stage 2 updates the channel accumulator and the output register in one edge.
module muladd_acc
    import muladd_pkg::*;
#(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned A_W      = 16,
    parameter int unsigned B_W      = 16,
    parameter int unsigned ACC_W    = 32,
    parameter int unsigned SAT_W    = 16,
    parameter int unsigned SHIFT    = 15,
    localparam int unsigned CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [CH_W-1:0]         in_ch,
    input  muladd_op_t              in_op,
    input  logic signed [A_W-1:0]   a,
    input  logic signed [B_W-1:0]   b,
    input  logic signed [ACC_W-1:0] c,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CH_W-1:0]         out_ch,
    output logic [ACC_W-1:0]        out_acc,
    output logic [SAT_W-1:0]        out_sat,
    output logic                    out_ovf
);

    localparam int unsigned PW = A_W + B_W;
    localparam int unsigned XW = ACC_W + 1;
    localparam logic [CH_W:0] CH_LIM = (CH_W+1)'(CHANNELS);

    logic                    s1_valid_q;
    logic [CH_W-1:0]         s1_ch_q;
    muladd_op_t              s1_op_q;
    logic signed [ACC_W-1:0] s1_c_q;
    logic signed [PW-1:0]    s1_p;

    logic signed [ACC_W-1:0] acc_q [CHANNELS];

    logic                    out_valid_q;
    logic [CH_W-1:0]         out_ch_q;
    logic [ACC_W-1:0]        out_acc_q;
    logic [SAT_W-1:0]        out_sat_q;
    logic                    out_ovf_q;

    logic                    accept;
    logic                    advance;
    logic                    ch_ok;
    logic signed [ACC_W-1:0] cur;
    logic signed [XW-1:0]    exact;
    logic signed [ACC_W-1:0] acc_d;
    logic                    ovf_d;
    logic [SAT_W-1:0]        sat_d;

    assign advance  = s1_valid_q && (!out_valid_q || out_ready);
    assign in_ready = !s1_valid_q || advance;
    assign accept   = in_valid && in_ready;

    muladd_mult #(
        .A_W (A_W),
        .B_W (B_W)
    ) u_mult (
        .clk_i (clk),
        .ce_i  (accept),
        .a_i   (a),
        .b_i   (b),
        .p_o   (s1_p)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_ch_q    <= '0;
            s1_op_q    <= MULADD_ADD;
            s1_c_q     <= '0;
        end else if (accept) begin
            s1_valid_q <= 1'b1;
            s1_ch_q    <= in_ch;
            s1_op_q    <= in_op;
            s1_c_q     <= c;
        end else if (advance) begin
            s1_valid_q <= 1'b0;
        end
    end

    // Out-of-range channels compute from zero and never write the array.
    always_comb begin
        ch_ok = ({1'b0, s1_ch_q} < CH_LIM);
        cur   = '0;
        if (ch_ok) begin
            cur = acc_q[s1_ch_q];
        end
        exact = '0;
        unique case (s1_op_q)
            MULADD_ADD:   exact = XW'(cur) + XW'(s1_p);
            MULADD_SUB:   exact = XW'(cur) - XW'(s1_p);
            MULADD_LOAD:  exact = XW'(s1_c_q) + XW'(s1_p);
            MULADD_CLEAR: exact = '0;
            default:      exact = '0;
        endcase
        acc_d = exact[ACC_W-1:0];
        ovf_d = (s1_op_q != MULADD_CLEAR) && (exact[ACC_W] != exact[ACC_W-1]);
        sat_d = SAT_W'(sat_shift(SAT_CALC_W'(acc_d), SHIFT, SAT_W));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                acc_q[i] <= '0;
            end
        end else if (advance && ch_ok) begin
            acc_q[s1_ch_q] <= acc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_acc_q   <= '0;
            out_sat_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else if (advance) begin
            out_valid_q <= 1'b1;
            out_ch_q    <= s1_ch_q;
            out_acc_q   <= acc_d;
            out_sat_q   <= sat_d;
            out_ovf_q   <= ovf_d;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_acc   = out_acc_q;
    assign out_sat   = out_sat_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_muladd_acc.sv
// Directed plus randomized checks of muladd_acc against an integer reference model.
module tb_muladd_acc;
    import muladd_pkg::*;

    localparam int unsigned CH = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [1:0]         in_ch;
    muladd_op_t         in_op;
    logic signed [15:0] a;
    logic signed [15:0] b;
    logic signed [31:0] c;
    logic               out_valid;
    logic               out_ready;
    logic [1:0]         out_ch;
    logic [31:0]        out_acc;
    logic [15:0]        out_sat;
    logic               out_ovf;

    always #5 clk = ~clk;

    muladd_acc #(
        .CHANNELS (4),
        .A_W      (16),
        .B_W      (16),
        .ACC_W    (32),
        .SAT_W    (16),
        .SHIFT    (15)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ch     (in_ch),
        .in_op     (in_op),
        .a         (a),
        .b         (b),
        .c         (c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch),
        .out_acc   (out_acc),
        .out_sat   (out_sat),
        .out_ovf   (out_ovf)
    );

    typedef struct {
        logic [1:0]  ch;
        logic [31:0] acc;
        logic [15:0] sat;
        logic        ovf;
    } exp_t;

    exp_t        exp_q[$];
    int          ref_acc[CH];
    logic [31:0] log_acc[$];
    logic [15:0] log_sat[$];
    logic        log_ovf[$];
    logic [1:0]  log_ch[$];

    int          n_cmp = 0;
    int          n_err = 0;
    logic        accepted;
    logic        last_in_ready;
    logic        hold_valid;
    logic [1:0]  held_ch;
    logic [31:0] held_acc;
    logic [15:0] held_sat;
    logic        held_ovf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Exact result in 64-bit integers; wrap, overflow and saturation follow from it.
    task automatic model_accept(input muladd_op_t op, input logic [1:0] ch,
                                input logic signed [15:0] ma, input logic signed [15:0] mb,
                                input logic signed [31:0] mc);
        longint cur;
        longint p;
        longint exact;
        longint s;
        int     w;
        exp_t   e;
        cur = (int'(ch) < int'(CH)) ? longint'(ref_acc[ch]) : 64'sd0;
        p   = longint'(ma) * longint'(mb);
        case (op)
            MULADD_ADD:  exact = cur + p;
            MULADD_SUB:  exact = cur - p;
            MULADD_LOAD: exact = longint'(mc) + p;
            default:     exact = 0;
        endcase
        w = int'(exact);
        s = longint'(w) >>> 15;
        if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
        e.ch  = ch;
        e.acc = w;
        e.sat = 16'(s);
        e.ovf = (longint'(w) != exact);
        if (int'(ch) < int'(CH)) ref_acc[ch] = w;
        exp_q.push_back(e);
    endtask

    task automatic cycle();
        exp_t e;
        @(negedge clk);
        last_in_ready = in_ready;
        accepted = 1'b0;
        if (rst) begin
            exp_q.delete();
            foreach (ref_acc[i]) ref_acc[i] = 0;
            hold_valid = 1'b0;
        end else begin
            if (hold_valid) begin
                chk("hold_valid", out_valid, 1'b1);
                chk("hold_ch", out_ch, held_ch);
                chk("hold_acc", out_acc, held_acc);
                chk("hold_sat", out_sat, held_sat);
                chk("hold_ovf", out_ovf, held_ovf);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out", out_valid, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_ch", out_ch, e.ch);
                    chk("out_acc", out_acc, e.acc);
                    chk("out_sat", out_sat, e.sat);
                    chk("out_ovf", out_ovf, e.ovf);
                    log_acc.push_back(out_acc);
                    log_sat.push_back(out_sat);
                    log_ovf.push_back(out_ovf);
                    log_ch.push_back(out_ch);
                end
            end
            hold_valid = out_valid && !out_ready;
            held_ch  = out_ch;
            held_acc = out_acc;
            held_sat = out_sat;
            held_ovf = out_ovf;
            if (in_valid && in_ready) begin
                accepted = 1'b1;
                model_accept(in_op, in_ch, a, b, c);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input muladd_op_t op, input logic [1:0] ch, input logic signed [15:0] va,
                        input logic signed [15:0] vb, input logic signed [31:0] vc);
        in_op = op; in_ch = ch; a = va; b = vb; c = vc; in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (accepted) break;
        end
        chk("send_accept", accepted, 1'b1);
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) cycle();
        chk("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, observed hang expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] t3_acc [4];
        logic [15:0] t3_sat [4];
        logic        t3_ovf [4];
        int          n;
        int          n_acc;

        t3_acc = '{32'h3FFF_0001, 32'h7FFE_0002, 32'hBFFD_0003, 32'hFFFC_0004};
        t3_sat = '{16'h7FFE, 16'h7FFF, 16'h8000, 16'hFFF8};
        t3_ovf = '{1'b0, 1'b0, 1'b1, 1'b0};

        rst = 1'b1; in_valid = 1'b0; in_op = MULADD_ADD; in_ch = '0;
        a = '0; b = '0; c = '0; out_ready = 1'b1;
        hold_valid = 1'b0; accepted = 1'b0;
        repeat (2) cycle();
        rst = 1'b0;

        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_ch", out_ch, 2'd0);
        chk("rst_out_acc", out_acc, 32'd0);
        chk("rst_out_sat", out_sat, 16'd0);
        chk("rst_out_ovf", out_ovf, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);

        // 1: two ADDs back to back, latency and running sum
        send(MULADD_ADD, 2'd0, 16'sd3, -16'sd5, 32'sd0);
        chk("t1_valid_after_s1", out_valid, 1'b0);
        send(MULADD_ADD, 2'd0, 16'sd3, -16'sd5, 32'sd0);
        chk("t1_valid_first", out_valid, 1'b1);
        chk("t1_acc_first", out_acc, 32'hFFFF_FFF1);
        in_valid = 1'b0;
        cycle();
        chk("t1_acc_second", out_acc, 32'hFFFF_FFE2);
        chk("t1_ch", out_ch, 2'd0);
        chk("t1_ovf", out_ovf, 1'b0);
        drain();

        // 2: LOAD overflowing to the most negative value, then a zero ADD
        send(MULADD_LOAD, 2'd1, 16'sd1, 16'sd16, 32'sh7FFF_FFF0);
        send(MULADD_ADD, 2'd1, 16'sd0, 16'sd0, 32'sd0);
        drain();
        n = log_acc.size();
        chk("t2_load_acc", log_acc[n-2], 32'h8000_0000);
        chk("t2_load_ovf", log_ovf[n-2], 1'b1);
        chk("t2_load_sat", log_sat[n-2], 16'h8000);
        chk("t2_add_acc", log_acc[n-1], 32'h8000_0000);
        chk("t2_add_ovf", log_ovf[n-1], 1'b0);

        // 3: four maximal products on one channel
        for (int i = 0; i < 4; i++) send(MULADD_ADD, 2'd2, 16'sh7FFF, 16'sh7FFF, 32'sd0);
        drain();
        n = log_acc.size();
        for (int i = 0; i < 4; i++) begin
            chk("t3_acc", log_acc[n-4+i], t3_acc[i]);
            chk("t3_sat", log_sat[n-4+i], t3_sat[i]);
            chk("t3_ovf", log_ovf[n-4+i], t3_ovf[i]);
        end

        // 4: backpressure with in_valid held high
        out_ready = 1'b0;
        n_acc = 0;
        in_op = MULADD_ADD; in_ch = 2'd2; a = 16'($urandom); b = 16'($urandom); c = '0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            if (accepted) begin
                n_acc++;
                a = 16'($urandom);
                b = 16'($urandom);
            end
        end
        chk("t4_accepts", n_acc, 2);
        chk("t4_ready_sampled", last_in_ready, 1'b0);
        chk("t4_ready_now", in_ready, 1'b0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();

        // 5: interleaved channels, then read all back
        send(MULADD_SUB, 2'd3, 16'sd2, 16'sd2, 32'sd0);
        send(MULADD_CLEAR, 2'd0, 16'sd7, 16'sd9, 32'sd0);
        send(MULADD_ADD, 2'd1, 16'sd1, 16'sd1, 32'sd0);
        for (int i = 0; i < 4; i++) send(MULADD_ADD, 2'(i), 16'sd0, 16'sd0, 32'sd0);
        drain();
        n = log_acc.size();
        chk("t5_ch0", log_acc[n-4], 32'd0);
        chk("t5_ch1", log_acc[n-3], 32'h8000_0001);
        chk("t5_ch3", log_acc[n-1], 32'hFFFF_FFFC);
        chk("t5_ch3_id", log_ch[n-1], 2'd3);

        // 6: reset while s1 and the output register both hold ops
        out_ready = 1'b0;
        send(MULADD_ADD, 2'd0, 16'sd1, 16'sd1, 32'sd0);
        send(MULADD_ADD, 2'd0, 16'sd1, 16'sd1, 32'sd0);
        rst = 1'b1;
        in_valid = 1'b0;
        cycle();
        rst = 1'b0;
        chk("t6_valid_after_rst", out_valid, 1'b0);
        chk("t6_ready_after_rst", in_ready, 1'b1);
        cycle();
        chk("t6_valid_no_ghost", out_valid, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send(MULADD_ADD, 2'(i), 16'sd0, 16'sd0, 32'sd0);
        drain();
        n = log_acc.size();
        for (int i = 0; i < 4; i++) chk("t6_acc_zero", log_acc[n-4+i], 32'd0);

        // random traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_op     = muladd_op_t'($urandom_range(0, 3));
            in_ch     = 2'($urandom_range(0, 3));
            a         = 16'($urandom);
            b         = 16'($urandom);
            c         = 32'($urandom);
            cycle();
        end
        out_ready = 1'b1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
